// File: rtl/param_thermo_counter.sv
// rtl/param_thermo_counter.sv - mod-MODULUS counter with prescaler, bounce mode and thermometer output
//
// Purpose: clock-enable prescaler (DIV cycles per step) driving a mod-MODULUS
// counter with hold/up/down/bounce modes and a saturating synchronous load.
// The count is also presented as a thermometer code for an LED bank.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - asynchronous active-low reset
//   en           - run enable; 0 freezes prescaler and counter
//   load         - synchronous load strobe (beats stepping)
//   in           - load value, clamped to MODULUS-1
//   mode         - 00 hold, 01 up, 10 down, 11 bounce
//   count        - registered count, always < MODULUS
//   thermo_count - bit i set when count > i
//   tick         - one-cycle pulse after each prescaler rollover
//   wrap         - one-cycle pulse on wrap-around or bounce reversal
module param_thermo_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int DIV     = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    load,
    input  logic [WIDTH-1:0]        in,
    input  logic [1:0]              mode,
    output logic [WIDTH-1:0]        count,
    output logic [(2**WIDTH)-2:0]   thermo_count,
    output logic                    tick,
    output logic                    wrap
);

    // A 1-bit prescaler still works for DIV = 1: it sits at 0, which is
    // also its last value, so every enabled cycle is a step.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] CNT_LAST   = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS = 2**WIDTH is representable for the clamp.
    localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH + 1)'(MODULUS);

    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    dir_e             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;

        if (load) begin
            // Load restarts the step period; direction is kept.
            presc_d = '0;
            count_d = ({1'b0, in} < MOD_EXT) ? in : CNT_LAST;
        end else if (en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                case (mode)
                    MODE_UP: begin
                        if (count_q == CNT_LAST) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    MODE_DOWN: begin
                        if (count_q == '0) begin
                            count_d = CNT_LAST;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q - 1'b1;
                        end
                    end
                    MODE_BOUNCE: begin
                        // Reversal steps away from the end value in the same
                        // edge, so the end value is shown for one period only.
                        if (dir_q == DIR_UP) begin
                            if (count_q == CNT_LAST) begin
                                count_d = CNT_LAST - 1'b1;
                                dir_d   = DIR_DOWN;
                                wrap_d  = 1'b1;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end else begin
                            if (count_q == '0) begin
                                count_d = WIDTH'(1);
                                dir_d   = DIR_UP;
                                wrap_d  = 1'b1;
                            end else begin
                                count_d = count_q - 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            count_q <= '0;
            dir_q   <= DIR_UP;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    for (genvar i = 0; i < (2**WIDTH) - 1; i++) begin : g_thermo
        localparam logic [WIDTH-1:0] IDX = WIDTH'(i);
        assign thermo_count[i] = (count_q > IDX);
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign wrap  = wrap_q;

endmodule
